// File: rtl/i2c_pkg.sv
// i2c_pkg: types and constants shared by the I2C target and controller.
//   i2c_tgt_state_t      target FSM states
//   I2C_ACK / I2C_NACK   SDA level of the acknowledge bit
//   I2C_RW_BIT           position of R/W in the address byte (1 = read)
//   I2C_*_HZ, helpers    bus-speed constants common to both endpoints
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int I2C_RW_BIT = 0;

    localparam int unsigned I2C_SYS_CLK_HZ       = 16_000_000;
    localparam int unsigned I2C_SCL_STD_HZ       = 100_000;
    localparam int unsigned I2C_SCL_FAST_HZ      = 400_000;
    // Shortest SCL high or low phase, in clk cycles, that the target resolves.
    localparam int unsigned I2C_MIN_PHASE_CYCLES = 6;

    // clk cycles in one SCL half period at the given bus rate.
    function automatic int unsigned i2c_half_period(input int unsigned scl_hz);
        return I2C_SYS_CLK_HZ / (2 * scl_hz);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings raw SCL/SDA into the clk domain and decodes bus events.
//   clk, rst          system clock, synchronous active-high reset
//   i_scl, i_sda      raw pin levels
//   o_sda            synchronized SDA, aligned with the event pulses
//   o_scl_rise/fall  one-cycle SCL edge pulses
//   o_start/o_stop   one-cycle START (SDA falls, SCL high) / STOP (SDA rises, SCL high)
// Pin-to-pulse latency is SYNC_STAGES + 1 clk cycles.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // Fewer than two flops would not resolve metastability.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_scl_sync;
    logic [STAGES-1:0] r_sda_sync;
    logic              r_scl_hist;
    logic              r_sda_hist;
    logic              r_scl_rise;
    logic              r_scl_fall;
    logic              r_start;
    logic              r_stop;

    logic w_scl;
    logic w_sda;

    assign w_scl = r_scl_sync[STAGES-1];
    assign w_sda = r_sda_sync[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to the idle-bus level so leaving reset on a quiet bus makes no event.
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop here sample the pre-edge
            // value of its neighbour, which is what makes this a shift chain.
            r_scl_sync <= {r_scl_sync[STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[STAGES-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_hist;
            r_scl_fall <= ~w_scl & r_scl_hist;
            // SCL must be high on both samples so an SDA edge coincident with an SCL edge is data.
            r_start    <= w_scl & r_scl_hist & ~w_sda &  r_sda_hist;
            r_stop     <= w_scl & r_scl_hist &  w_sda & ~r_sda_hist;
        end
    end

    // The history flop holds the SDA level the registered pulses were decoded from.
    assign o_sda      = r_sda_hist;
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with a pointer-based 8-bit register port.
//   clk, rst     system clock, synchronous active-high reset
//   scl_i, sda_i raw bus pin levels
//   sda_oe       1 = pull SDA low, 0 = release
//   reg_addr     register pointer for the current access
//   reg_we       one-cycle write strobe, reg_wdata valid with it
//   reg_re       one-cycle read request; reg_rdata is captured on the next clk edge
//   busy         high from a matched address ACK until STOP, read NACK or mismatch
// The first byte after a write address loads the pointer; every data byte
// written or ACKed on read advances it with mod-256 wrap.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_we,
    output logic [7:0] reg_wdata,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_tgt_state_t r_state;
    i2c_tgt_state_t w_state_next;

    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_reg_we;
    logic [7:0] r_reg_wdata;
    logic       r_load;      // reg_rdata is valid: load the shift register
    logic       r_drive;     // shift register loaded: put its MSB on SDA
    logic       r_rd_acked;  // controller ACKed the last read byte

    logic w_reg_re;
    logic w_byte_done;
    logic w_addr_match;

    assign w_byte_done  = (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_reg_re     = 1'b0;
        if (w_stop) begin
            w_state_next = ST_IDLE;
        end else if (w_start) begin
            w_state_next = ST_ADDR;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_IGNORE: ;
                ST_ADDR:
                    if (w_scl_fall && w_byte_done)
                        w_state_next = w_addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_state_next = ST_RD_DATA;
                            w_reg_re     = 1'b1;
                        end else begin
                            w_state_next = ST_PTR;
                        end
                    end
                ST_PTR, ST_WR_DATA:
                    if (w_scl_fall && w_byte_done) w_state_next = ST_WR_ACK;
                ST_WR_ACK:
                    if (w_scl_fall) w_state_next = ST_WR_DATA;
                ST_RD_DATA:
                    if (w_scl_fall && w_byte_done) w_state_next = ST_RD_ACK;
                ST_RD_ACK:
                    if (w_scl_rise && (w_sda == I2C_NACK)) begin
                        w_state_next = ST_IGNORE;
                    end else if (w_scl_fall && r_rd_acked) begin
                        w_state_next = ST_RD_DATA;
                        w_reg_re     = 1'b1;
                    end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= '0;
            r_load      <= 1'b0;
            r_drive     <= 1'b0;
            r_rd_acked  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_reg_we <= 1'b0;
            r_load   <= w_reg_re;
            r_drive  <= r_load;
            // The pointer advances in the cycle after the write strobe was seen.
            if (r_reg_we) r_ptr <= r_ptr + 8'd1;

            if (w_stop) begin
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
                r_bit_cnt  <= '0;
                r_rd_acked <= 1'b0;
                r_load     <= 1'b0;
                r_drive    <= 1'b0;
            end else if (w_start) begin
                // Repeated START: pointer and busy are kept for the next access.
                r_sda_oe   <= 1'b0;
                r_bit_cnt  <= '0;
                r_rd_acked <= 1'b0;
                r_load     <= 1'b0;
                r_drive    <= 1'b0;
            end else begin
                if (r_load) r_shift <= reg_rdata;
                if (r_drive) begin
                    r_sda_oe  <= ~r_shift[7];
                    r_shift   <= {r_shift[6:0], 1'b0};
                    r_bit_cnt <= 4'd1;
                end

                unique case (r_state)
                    ST_ADDR, ST_PTR, ST_WR_DATA: begin
                        if (w_scl_rise && !w_byte_done) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        if (w_scl_rise && (r_bit_cnt == 4'd7) && (r_state == ST_WR_DATA)) begin
                            r_reg_we    <= 1'b1;
                            r_reg_wdata <= {r_shift[6:0], w_sda};
                        end
                        // Byte decisions wait for SCL to fall, so a START/STOP in
                        // the 8th high phase still overrides them.
                        if (w_scl_fall && w_byte_done) begin
                            r_bit_cnt <= '0;
                            if (r_state == ST_ADDR) begin
                                if (w_addr_match) begin
                                    r_sda_oe <= 1'b1;
                                    r_busy   <= 1'b1;
                                    r_rw     <= r_shift[I2C_RW_BIT];
                                end else begin
                                    r_busy <= 1'b0;
                                end
                            end else begin
                                r_sda_oe <= 1'b1;
                                if (r_state == ST_PTR) r_ptr <= r_shift;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (w_byte_done) begin
                                r_sda_oe   <= 1'b0;
                                r_bit_cnt  <= '0;
                                r_rd_acked <= 1'b0;
                            end else begin
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == I2C_ACK) begin
                                r_rd_acked <= 1'b1;
                                r_ptr      <= r_ptr + 8'd1;
                            end else begin
                                r_busy <= 1'b0;
                            end
                        end
                        if (w_scl_fall && r_rd_acked) r_rd_acked <= 1'b0;
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Reset must free the bus in the cycle it is seen, not one edge later.
    assign sda_oe    = r_sda_oe & ~rst;
    assign reg_re    = w_reg_re & ~rst;
    assign reg_addr  = r_ptr;
    assign reg_we    = r_reg_we;
    assign reg_wdata = r_reg_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: drives the target as a bus controller and scoreboards the
// register-port strobes and read data against bench-side expectations.
module tb_i2c_target;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_scl;
    logic       tb_sda_low;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_wr[$];   // {addr, data} per expected write strobe
    logic [7:0]  exp_re[$];   // address per expected read request
    logic [7:0]  exp_rd[$];   // expected bytes seen on SDA

    int we_cnt = 0;
    int re_cnt = 0;
    int oe_cnt = 0;
    logic prev_we = 1'b0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of controller and target.
    assign sda_line = ~(tb_sda_low | sda_oe);

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    assign reg_rdata = model_rd(reg_addr);

    i2c_target #(
        .DEV_ADDR    (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (tb_scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                we_cnt++;
                check("we_single_cycle", 32'(prev_we), 0);
                if (exp_wr.size() == 0) check("we_unexpected", 32'({reg_addr, reg_wdata}), 32'hFFFF_FFFF);
                else check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
            end
            if (reg_re) begin
                re_cnt++;
                if (exp_re.size() == 0) check("re_unexpected", 32'(reg_addr), 32'hFFFF_FFFF);
                else check("re_addr", 32'(reg_addr), 32'(exp_re.pop_front()));
            end
            if (sda_oe) oe_cnt++;
        end
        prev_we = reg_we;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL timeout: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        tb_sda_low = 1'b0;
        wait_clk(12);
        tb_scl = 1'b1;
        wait_clk(6);
        tb_sda_low = 1'b1;
        wait_clk(6);
        tb_scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(6);
        tb_sda_low = 1'b1;
        wait_clk(6);
        tb_scl = 1'b1;
        wait_clk(6);
        tb_sda_low = 1'b0;
        wait_clk(12);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(6);
        tb_sda_low = ~b;
        wait_clk(6);
        tb_scl = 1'b1;
        wait_clk(12);
        tb_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(6);
        tb_sda_low = 1'b0;
        wait_clk(6);
        tb_scl = 1'b1;
        wait_clk(6);
        b = sda_line;
        wait_clk(6);
        tb_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
    endtask

    logic       ack;
    logic       b;
    logic [7:0] rbyte;
    logic [4:0] rbits;
    int         snap_we, snap_re, snap_oe;
    logic [7:0] wr_bytes[3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        // NOTE: the bench drives inputs with blocking assignments just after a
        // clock edge, so the DUT never samples a value changing on its edge.
        rst        = 1'b1;
        tb_scl     = 1'b1;
        tb_sda_low = 1'b0;
        wait_clk(5);
        check("rst_sda_oe",    32'(sda_oe), 0);
        check("rst_reg_we",    32'(reg_we), 0);
        check("rst_reg_re",    32'(reg_re), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_reg_addr",  32'(reg_addr), 0);
        check("rst_reg_wdata", 32'(reg_wdata), 0);
        rst = 1'b0;
        wait_clk(10);

        // Plain write of two bytes starting at pointer 0x05.
        snap_we = we_cnt;
        exp_wr.push_back({8'h05, 8'hA5});
        exp_wr.push_back({8'h06, 8'h3C});
        start_cond();
        write_byte(8'h84, ack); check("t1_ack_addr", 32'(ack), 32'(I2C_ACK));
        check("t1_busy_on", 32'(busy), 1);
        write_byte(8'h05, ack); check("t1_ack_ptr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'hA5, ack); check("t1_ack_d0", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h3C, ack); check("t1_ack_d1", 32'(ack), 32'(I2C_ACK));
        stop_cond();
        check("t1_busy_off", 32'(busy), 0);
        check("t1_we_count", 32'(we_cnt - snap_we), 2);

        // Set pointer, repeated START, read two bytes (ACK then NACK).
        start_cond();
        write_byte(8'h84, ack); check("t2_ack_waddr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h10, ack); check("t2_ack_ptr", 32'(ack), 32'(I2C_ACK));
        exp_re.push_back(8'h10); exp_rd.push_back(model_rd(8'h10));
        exp_re.push_back(8'h11); exp_rd.push_back(model_rd(8'h11));
        start_cond();
        write_byte(8'h85, ack); check("t2_ack_raddr", 32'(ack), 32'(I2C_ACK));
        read_byte(rbyte, I2C_ACK);  check("t2_rd0", 32'(rbyte), 32'(exp_rd.pop_front()));
        read_byte(rbyte, I2C_NACK); check("t2_rd1", 32'(rbyte), 32'(exp_rd.pop_front()));
        wait_clk(6);
        check("t2_state_ignore", 32'(dut.r_state), 32'(ST_IGNORE));
        check("t2_busy_nack", 32'(busy), 0);
        check("t2_sda_released", 32'(sda_oe), 0);
        stop_cond();

        // Foreign address 0x43: no ACK, no strobes, never busy.
        snap_we = we_cnt; snap_re = re_cnt; snap_oe = oe_cnt;
        start_cond();
        write_byte(8'h86, ack); check("t3_nack_addr", 32'(ack), 32'(I2C_NACK));
        check("t3_busy", 32'(busy), 0);
        write_byte(8'h00, ack); check("t3_nack_data", 32'(ack), 32'(I2C_NACK));
        stop_cond();
        check("t3_oe_never", 32'(oe_cnt - snap_oe), 0);
        check("t3_no_we", 32'(we_cnt - snap_we), 0);
        check("t3_no_re", 32'(re_cnt - snap_re), 0);

        // Pointer wrap from 0xFF.
        exp_wr.push_back({8'hFF, 8'h11});
        exp_wr.push_back({8'h00, 8'h22});
        exp_wr.push_back({8'h01, 8'h33});
        start_cond();
        write_byte(8'h84, ack); check("t4_ack_addr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'hFF, ack); check("t4_ack_ptr", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 3; i++) begin
            write_byte(wr_bytes[i], ack);
            check("t4_ack_data", 32'(ack), 32'(I2C_ACK));
        end
        stop_cond();
        check("t4_reg_addr_wrapped", 32'(reg_addr), 32'h02);

        // STOP four bits into a data byte.
        snap_we = we_cnt;
        start_cond();
        write_byte(8'h84, ack); check("t5_ack_addr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h20, ack); check("t5_ack_ptr", 32'(ack), 32'(I2C_ACK));
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        stop_cond();
        check("t5_no_we", 32'(we_cnt - snap_we), 0);
        check("t5_sda_oe", 32'(sda_oe), 0);
        check("t5_state_idle", 32'(dut.r_state), 32'(ST_IDLE));

        // START in the middle of a read byte (data 0x85 = 1000_0101).
        exp_re.push_back(8'h20);
        start_cond();
        write_byte(8'h85, ack); check("t5_ack_raddr", 32'(ack), 32'(I2C_ACK));
        for (int i = 4; i >= 0; i--) begin
            recv_bit(b);
            rbits[i] = b;
        end
        check("t5_rd_bits", 32'(rbits), 32'h10);
        start_cond();
        wait_clk(4);
        check("t5_start_release", 32'(sda_oe), 0);
        check("t5_state_addr", 32'(dut.r_state), 32'(ST_ADDR));
        stop_cond();

        // Reset while the target pulls SDA low for a read bit.
        exp_re.push_back(8'h20);
        start_cond();
        write_byte(8'h85, ack); check("t6_ack_raddr", 32'(ack), 32'(I2C_ACK));
        recv_bit(b); check("t6_msb", 32'(b), 1);
        begin : wait_drive
            int waited;
            waited = 0;
            while (!sda_oe && waited < 20) begin
                wait_clk(1);
                waited++;
            end
            check("t6_driving_low", 32'(sda_oe), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_sda_oe", 32'(sda_oe), 0);
        wait_clk(2);
        check("t6_rst_reg_we", 32'(reg_we), 0);
        check("t6_rst_reg_re", 32'(reg_re), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_reg_addr", 32'(reg_addr), 0);
        check("t6_rst_reg_wdata", 32'(reg_wdata), 0);
        tb_scl     = 1'b1;
        tb_sda_low = 1'b0;
        rst        = 1'b0;
        wait_clk(20);
        check("t6_state_idle", 32'(dut.r_state), 32'(ST_IDLE));

        exp_wr.push_back({8'h30, 8'h77});
        start_cond();
        write_byte(8'h84, ack); check("t6_ack_addr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h30, ack); check("t6_ack_ptr", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h77, ack); check("t6_ack_data", 32'(ack), 32'(I2C_ACK));
        stop_cond();

        wait_clk(10);
        check("end_wr_queue", 32'(exp_wr.size()), 0);
        check("end_re_queue", 32'(exp_re.size()), 0);
        check("end_rd_queue", 32'(exp_rd.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
